// File: rtl/seq_frame_tx_if.sv
// Load handshake and serial-line bundle for seq_frame_tx.
// The master side supplies frames; the slave side is the transmitter.
interface seq_frame_tx_if #(
    parameter int FRAME_W = 3
);
    logic [FRAME_W-1:0] load_data;
    logic               load_valid;
    logic               load_ready;
    logic [3:0]         repeat_cnt;
    logic               ser_out;
    logic               ser_valid;
    logic               frame_start;
    logic               busy;
    logic               done;

    modport master (
        output load_data, load_valid, repeat_cnt,
        input  load_ready, ser_out, ser_valid, frame_start, busy, done
    );

    modport slave (
        input  load_data, load_valid, repeat_cnt,
        output load_ready, ser_out, ser_valid, frame_start, busy, done
    );
endinterface

// File: rtl/seq_frame_tx.sv
// MSB-first serial frame transmitter with repeat count and idle gaps.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module seq_frame_tx #(
    parameter int   FRAME_W    = 3,
    parameter int   GAP_CYCLES = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    seq_frame_tx_if.slave  bus_io
);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_e;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
`endif

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] word_q, word_d;
    logic [3:0]         bitCnt_q, bitCnt_d;
    logic [3:0]         repCnt_q, repCnt_d;
    logic [3:0]         gapCnt_q, gapCnt_d;
    logic               serOut_q, serOut_d;
    logic               serValid_q, serValid_d;
    logic               frameStart_q, frameStart_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               startFrame;
    logic               endFrame;
    logic [FRAME_W-1:0] startWord;

    assign bus_io.load_ready  = (state_q == IDLE) & ~rst;
    assign bus_io.ser_out     = serOut_q;
    assign bus_io.ser_valid   = serValid_q;
    assign bus_io.frame_start = frameStart_q;
    assign bus_io.busy        = busy_q;
    assign bus_io.done        = done_q;

    // The _d values describe what the line carries in the cycle after the
    // coming edge, so every output leaves the block straight from a flop.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        word_d       = word_q;
        bitCnt_d     = bitCnt_q;
        repCnt_d     = repCnt_q;
        gapCnt_d     = gapCnt_q;
        serOut_d     = IDLE_LEVEL;
        serValid_d   = 1'b0;
        frameStart_d = 1'b0;
        done_d       = 1'b0;
        startFrame   = 1'b0;
        endFrame     = 1'b0;
        startWord    = word_q;

        case (state_q)
            IDLE: begin
                if (bus_io.load_valid) begin
                    startFrame = 1'b1;
                    startWord  = bus_io.load_data;
                    word_d     = bus_io.load_data;
                    repCnt_d   = bus_io.repeat_cnt;
                end
            end
            SHIFT: begin
                // bitCnt_q counts the bits still to follow the one on the line.
                if (bitCnt_q != 4'd0) begin
                    serOut_d   = shift_q[FRAME_W-1];
                    serValid_d = 1'b1;
                    shift_d    = shift_q << 1;
                    bitCnt_d   = bitCnt_q - 4'd1;
                end else begin
`ifdef SER_PARITY_EN
                    state_d    = PAR;
                    serOut_d   = ^word_q;
                    serValid_d = 1'b1;
`else
                    endFrame   = 1'b1;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                endFrame = 1'b1;
            end
`endif
            GAP: begin
                if (gapCnt_q == 4'd0) begin
                    startFrame = 1'b1;
                end else begin
                    gapCnt_d = gapCnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (endFrame) begin
            if (repCnt_q != 4'd0) begin
                repCnt_d = repCnt_q - 4'd1;
                if (GAP_CYCLES == 0) begin
                    startFrame = 1'b1;
                end else begin
                    state_d  = GAP;
                    gapCnt_d = 4'(GAP_CYCLES - 1);
                end
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        if (startFrame) begin
            state_d      = SHIFT;
            serOut_d     = startWord[FRAME_W-1];
            serValid_d   = 1'b1;
            frameStart_d = 1'b1;
            shift_d      = startWord << 1;
            bitCnt_d     = 4'(FRAME_W - 1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            word_q       <= '0;
            bitCnt_q     <= '0;
            repCnt_q     <= '0;
            gapCnt_q     <= '0;
            serOut_q     <= IDLE_LEVEL;
            serValid_q   <= 1'b0;
            frameStart_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            bitCnt_q     <= bitCnt_d;
            repCnt_q     <= repCnt_d;
            gapCnt_q     <= gapCnt_d;
            serOut_q     <= serOut_d;
            serValid_q   <= serValid_d;
            frameStart_q <= frameStart_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: a 3-bit/gap-1 instance and a
// 1-bit/gap-0 instance, each compared cycle by cycle against a frame-list model.
module tb_seq_frame_tx;

    localparam logic IDLE_LVL = 1'b0;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    // Expected {ser_out, ser_valid, frame_start, busy, done, load_ready} per cycle.
    logic [5:0] expQ[$];

    seq_frame_tx_if #(.FRAME_W(3)) bus0 ();
    seq_frame_tx_if #(.FRAME_W(1)) bus1 ();

    seq_frame_tx #(.FRAME_W(3), .GAP_CYCLES(1), .IDLE_LEVEL(IDLE_LVL)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus0)
    );

    seq_frame_tx #(.FRAME_W(1), .GAP_CYCLES(0), .IDLE_LEVEL(IDLE_LVL)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] obsVec(input int sel);
        if (sel == 0)
            return {bus0.ser_out, bus0.ser_valid, bus0.frame_start,
                    bus0.busy, bus0.done, bus0.load_ready};
        else
            return {bus1.ser_out, bus1.ser_valid, bus1.frame_start,
                    bus1.busy, bus1.done, bus1.load_ready};
    endfunction

    task automatic checkOutput(input string tag, input logic [5:0] observed,
                               input logic [5:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic driveInputs(input int sel, input logic valid,
                               input logic [15:0] data, input logic [3:0] rep);
        if (sel == 0) begin
            bus0.load_valid = valid;
            bus0.load_data  = data[2:0];
            bus0.repeat_cnt = rep;
        end else begin
            bus1.load_valid = valid;
            bus1.load_data  = data[0];
            bus1.repeat_cnt = rep;
        end
    endtask

    // Frame list: (rep+1) copies of the data bits MSB first, optional parity
    // bit, gap cycles between copies, then a single done/ready cycle.
    task automatic modelTransfer(input logic [15:0] data, input int w,
                                 input int gap, input int rep);
        expQ.delete();
        for (int f = 0; f <= rep; f++) begin
            for (int b = w - 1; b >= 0; b--)
                expQ.push_back({data[b], 1'b1, 1'(b == w - 1), 1'b1, 1'b0, 1'b0});
`ifdef SER_PARITY_EN
            begin
                int ones = 0;
                for (int b = 0; b < w; b++) ones += int'(data[b]);
                expQ.push_back({1'(ones % 2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
            end
`endif
            if (f < rep)
                for (int g = 0; g < gap; g++)
                    expQ.push_back({IDLE_LVL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        expQ.push_back({IDLE_LVL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    endtask

    // Starts one transfer and checks every cycle up to and including done.
    // Returns in the done cycle, so a following call is a back-to-back accept.
    task automatic applyStimulus(input int sel, input logic [15:0] data,
                                 input logic [3:0] rep, input bit noise);
        modelTransfer(data, (sel == 0) ? 3 : 1, (sel == 0) ? 1 : 0, int'(rep));
        driveInputs(sel, 1'b1, data, rep);
        @(posedge clk); #1;
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (noise && i < expQ.size() - 1)
                driveInputs(sel, 1'b1, 16'($urandom), 4'($urandom));
            else
                driveInputs(sel, 1'b0, 16'h0, 4'h0);
            checkOutput($sformatf("dut%0d_d%0h_r%0d_cyc%0d", sel, data, rep, i),
                        obsVec(sel), expQ[i]);
        end
    endtask

    task automatic idleCycles(input int sel, input int n);
        driveInputs(sel, 1'b0, 16'h0, 4'h0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("dut%0d_idle%0d", sel, i), obsVec(sel),
                        {IDLE_LVL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        end
    endtask

    initial begin
        $display("[TB] starting seq_frame_tx bench");
        rst = 1'b1;
        driveInputs(0, 1'b0, 16'h0, 4'h0);
        driveInputs(1, 1'b0, 16'h0, 4'h0);

        // Reset values, with load_ready held low while rst is high.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_dut0", obsVec(0), {IDLE_LVL, 5'b00000});
        checkOutput("reset_dut1", obsVec(1), {IDLE_LVL, 5'b00000});
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", obsVec(0), {IDLE_LVL, 5'b00001});

        // Single frame, then three frames with gaps accepted in the done cycle.
        applyStimulus(0, 16'b101, 4'd0, 1'b0);
        applyStimulus(0, 16'b011, 4'd2, 1'b1);
        idleCycles(0, 2);

        // Reset on the second bit of the first frame of a repeat-3 transfer.
        driveInputs(0, 1'b1, 16'b110, 4'd3);
        @(posedge clk); #1;
        driveInputs(0, 1'b0, 16'h0, 4'h0);
        checkOutput("abort_bit0", obsVec(0), {1'b1, 5'b11100});
        @(posedge clk); #1;
        checkOutput("abort_bit1", obsVec(0), {1'b1, 5'b10100});
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_in_reset", obsVec(0), {IDLE_LVL, 5'b00000});
        rst = 1'b0;
        #1;
        checkOutput("abort_ready", obsVec(0), {IDLE_LVL, 5'b00001});
        idleCycles(0, 5);

        // Randomized transfers, some back-to-back, some with ignored load noise.
        for (int t = 0; t < 10; t++) begin
            applyStimulus(0, 16'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1)
                idleCycles(0, $urandom_range(1, 2));
        end
        idleCycles(0, 1);

        // One-bit frames with no gap: every bit is a frame start.
        applyStimulus(1, 16'h1, 4'd3, 1'b0);
        applyStimulus(1, 16'h0, 4'd1, 1'b1);
        for (int t = 0; t < 4; t++)
            applyStimulus(1, 16'($urandom_range(0, 1)), 4'($urandom_range(0, 4)),
                          1'($urandom_range(0, 1)));
        idleCycles(1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
